// File: rtl/npu_pkg.sv
// Shared NPU types: accumulator/data widths, signed payload typedefs and the
// drain FSM state enum.
package npu_pkg;

   localparam int unsigned ACC_W   = 20;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned SCALE_W = 16;
   localparam int unsigned SHIFT_W = 5;
   localparam int unsigned PROD_W  = 37;

   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

endpackage

// File: rtl/requant_int8.sv
// requant_int8: combinational accumulator -> int8 requantizer.
//   acc        : 20-bit signed accumulator
//   scale      : 16-bit unsigned multiplier
//   shift      : 0..31 rounding right shift (round half toward +inf)
//   zero_point : signed int8 output offset
//   data       : saturated int8 result
//   sat        : result was clamped to [-128,127]
// Optional: ACC_DRAIN_RELU_EN clamps the result at zero_point before saturation
// (that clamp does not count as saturation).
module requant_int8
   import npu_pkg::*;
(
   input  acc_t               acc,
   input  logic [SCALE_W-1:0] scale,
   input  logic [SHIFT_W-1:0] shift,
   input  data_t              zero_point,
   output data_t              data,
   output logic               sat
);

   localparam int unsigned R_W = PROD_W + 1;
   localparam logic signed [R_W-1:0] MAX_V = R_W'(127);
   localparam logic signed [R_W-1:0] MIN_V = -R_W'(128);

   logic signed [PROD_W-1:0] acc_x;
   logic signed [PROD_W-1:0] scl_x;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] rnd;
   logic signed [PROD_W-1:0] shifted;
   logic signed [R_W-1:0]    res;
   logic signed [R_W-1:0]    zp_x;

   // Multiply, round, arithmetic shift, offset, then clamp to int8.
   always_comb begin
      acc_x = PROD_W'(acc);
      scl_x = PROD_W'($signed({1'b0, scale}));
      prod  = acc_x * scl_x;
      rnd   = '0;
      if (shift != '0) begin
         rnd[6'({1'b0, shift}) - 6'd1] = 1'b1;
      end
      shifted = (prod + rnd) >>> shift;
      zp_x    = R_W'(zero_point);
      res     = R_W'(shifted) + zp_x;
`ifdef ACC_DRAIN_RELU_EN
      if (res < zp_x) begin
         res = zp_x;
      end
`endif
      sat  = 1'b0;
      data = DATA_W'(res);
      if (res > MAX_V) begin
         data = DATA_W'(127);
         sat  = 1'b1;
      end else if (res < MIN_V) begin
         data = -DATA_W'(128);
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/acc_drain_quant.sv
// acc_drain_quant: drain stage for the systolic MAC array.
// Snapshots N accumulators on capture, pulses clear_acc_o once, then streams
// the int8-requantized values out over valid/ready, one element per cycle.
//   clock, reset_n       : clock, async active-low reset
//   capture              : snapshot acc_in/scale/shift/zero_point when idle
//   acc_in               : packed accumulators, element i at [i*ACC_W +: ACC_W]
//   clear_acc_o          : one-cycle clear to the array after an accepted capture
//   busy                 : tile held or still draining
//   out_valid/out_ready  : output handshake
//   out_data/idx/last    : quantized value, element index, last-element flag
//   sat_flag             : sticky, some element of the current tile saturated
// Optional: ACC_DRAIN_RELU_EN enables a ReLU clamp inside requant_int8.
module acc_drain_quant
   import npu_pkg::*;
#(
   parameter  int unsigned N     = 4,
   parameter  int unsigned ACC_W = 20,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
)(
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 capture,
   input  logic [N*ACC_W-1:0]   acc_in,
   input  logic [15:0]          scale,
   input  logic [4:0]           shift,
   input  logic signed [7:0]    zero_point,
   output logic                 clear_acc_o,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [7:0]    out_data,
   output logic [IDX_W-1:0]     out_idx,
   output logic                 out_last,
   output logic                 sat_flag
);

   drain_state_e state, state_nxt;

   logic [ACC_W-1:0]   snap [N];
   logic [15:0]        scale_r;
   logic [4:0]         shift_r;
   data_t              zp_r;
   logic [IDX_W-1:0]   idx;

   logic               cap_ok;
   logic               load;
   logic               last_el;
   logic               valid_nxt;
   logic               busy_nxt;
   data_t              rq_data;
   logic               rq_sat;

   requant_int8 u_requant (
      .acc        (acc_t'(snap[idx])),
      .scale      (scale_r),
      .shift      (shift_r),
      .zero_point (zp_r),
      .data       (rq_data),
      .sat        (rq_sat)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state, capture acceptance and output-register load decision.
   always_comb begin
      state_nxt = state;
      cap_ok    = 1'b0;
      load      = 1'b0;
      last_el   = (idx == IDX_W'(N - 1));
      case (state)
         IDLE: begin
            // out_valid may still hold the previous tile's last element.
            if (capture && !out_valid) begin
               cap_ok    = 1'b1;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!out_valid || out_ready) begin
               load = 1'b1;
               if (last_el) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      valid_nxt = out_valid;
      if (load)           valid_nxt = 1'b1;
      else if (out_ready) valid_nxt = 1'b0;
      busy_nxt = (state_nxt == DRAIN) || valid_nxt;
   end

   // Snapshot buffer, index and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) snap[i] <= '0;
         scale_r     <= '0;
         shift_r     <= '0;
         zp_r        <= '0;
         idx         <= '0;
         clear_acc_o <= 1'b0;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_idx     <= '0;
         out_last    <= 1'b0;
         sat_flag    <= 1'b0;
      end else begin
         clear_acc_o <= cap_ok;
         busy        <= busy_nxt;
         out_valid   <= valid_nxt;
         if (cap_ok) begin
            for (int i = 0; i < N; i++) snap[i] <= acc_in[i*ACC_W +: ACC_W];
            scale_r  <= scale;
            shift_r  <= shift;
            zp_r     <= zero_point;
            idx      <= '0;
            sat_flag <= 1'b0;
         end
         if (load) begin
            out_data <= rq_data;
            out_idx  <= idx;
            out_last <= last_el;
            if (rq_sat) sat_flag <= 1'b1;
            idx <= last_el ? '0 : idx + 1'b1;
         end
      end
   end

endmodule
